rec_f32_to_f32_arbiter: RTL and testbench

//  Shares one recoded-F32 (33b) -> IEEE F32 (32b) conversion core among NUM_REQ requesters.

---
 rtl/rec_fn_pkg.sv | 39 +++
 rtl/rec_f32_to_f32_arbiter_if.sv | 46 ++++
 rtl/rec_f32_to_f32_core.sv | 48 ++++
 rtl/rec_f32_to_f32_arbiter.sv | 132 +++++++++++++
 tb/tb_rec_f32_to_f32_arbiter.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rec_fn_pkg.sv
// Shared types and constants for the recoded-F32 to IEEE-F32 conversion arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package rec_fn_pkg;

    localparam int NUM_REQ = 4;
    localparam int SRC_W   = $clog2(NUM_REQ);
    localparam int CNT_W   = 16;

    localparam int REC_F32_W = 33;
    localparam int F32_W     = 32;

    // Recoded exponent is offset by 0x81 relative to the IEEE biased exponent.
    localparam logic [7:0] EXP_BIAS_ADJ     = 8'h81;
    // Smallest recoded exponent that still maps onto a normal IEEE number.
    localparam logic [8:0] MIN_NORM_REC_EXP = 9'h082;

    // Operand waiting in front of the conversion logic.
    typedef struct packed {
        logic [SRC_W-1:0]     src;
        logic [REC_F32_W-1:0] op;
    } s0_entry_t;

    // Converted result waiting for the consumer.
    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic             is_bad_nan;
        logic [F32_W-1:0] bits;
    } s1_entry_t;

    // Next requester index after idx, wrapping at NUM_REQ.
    function automatic logic [SRC_W-1:0] wrap_inc(input logic [SRC_W-1:0] idx);
        if (int'(idx) == NUM_REQ - 1) begin
            return '0;
        end
        return idx + SRC_W'(1);
    endfunction

endpackage

// File: rtl/rec_f32_to_f32_arbiter_if.sv
// Requester/consumer bundle of the shared recoded-F32 conversion unit.
// Latency: n/a (wiring only).
// Backpressure: req side valid/ready per requester, resp side single valid/ready.
interface rec_f32_to_f32_arbiter_if;
    import rec_fn_pkg::*;

    logic [NUM_REQ-1:0]           io_req_valid;
    logic [NUM_REQ-1:0]           io_req_ready;
    logic [REC_F32_W*NUM_REQ-1:0] io_req_bits;
    logic                         io_resp_valid;
    logic                         io_resp_ready;
    logic [F32_W-1:0]             io_resp_bits;
    logic [SRC_W-1:0]             io_resp_src;
    logic                         io_resp_isBadNaN;
    logic [CNT_W-1:0]             io_badNaN_count;
    logic                         io_badNaN_clear;

    // Requesters plus consumer side (drives operands, takes results).
    modport master (
        output io_req_valid,
        output io_req_bits,
        output io_resp_ready,
        output io_badNaN_clear,
        input  io_req_ready,
        input  io_resp_valid,
        input  io_resp_bits,
        input  io_resp_src,
        input  io_resp_isBadNaN,
        input  io_badNaN_count
    );

    // Conversion unit side.
    modport slave (
        input  io_req_valid,
        input  io_req_bits,
        input  io_resp_ready,
        input  io_badNaN_clear,
        output io_req_ready,
        output io_resp_valid,
        output io_resp_bits,
        output io_resp_src,
        output io_resp_isBadNaN,
        output io_badNaN_count
    );

endinterface

// File: rtl/rec_f32_to_f32_core.sv
// Converts one 33-bit recoded F32 operand to IEEE F32 and flags non-canonical NaNs.
// Latency: purely combinational.
// Backpressure: none, stateless.
module rec_f32_to_f32_core
    import rec_fn_pkg::*;
(
    input  logic [REC_F32_W-1:0] rec_i,
    output logic [F32_W-1:0]     f32_o,
    output logic                 is_bad_nan_o
);

    logic        sign;
    logic [8:0]  rexp;
    logic [22:0] frac_in;
    logic [23:0] sub_sig;
    logic [4:0]  sub_shamt;
    logic [22:0] sub_frac;

    assign sign    = rec_i[32];
    assign rexp    = rec_i[31:23];
    assign frac_in = rec_i[22:0];

    // Subnormals: restore the hidden one, then shift right by the distance below
    // the normal range. The 5-bit distance wraps exactly as the recoding expects.
    assign sub_sig   = {1'b1, frac_in} >> 1;
    assign sub_shamt = 5'd1 - rexp[4:0];
    assign sub_frac  = 23'(sub_sig >> sub_shamt);

    // Classify the recoded exponent and assemble the IEEE word.
    always_comb begin
        f32_o = '0;
        if (rexp[8:6] == 3'b000) begin
            f32_o = {sign, 8'h00, 23'h0};
        end else if (rexp[8:7] == 2'b11 && !rexp[6]) begin
            f32_o = {sign, 8'hFF, 23'h0};
        end else if (rexp[8:7] == 2'b11) begin
            f32_o = {sign, 8'hFF, frac_in};
        end else if (rexp < MIN_NORM_REC_EXP) begin
            f32_o = {sign, 8'h00, sub_frac};
        end else begin
            f32_o = {sign, rexp[7:0] - EXP_BIAS_ADJ, frac_in};
        end
    end

    // A canonical recoded NaN carries all-ones in the low 24 bits.
    assign is_bad_nan_o = (rec_i[31:29] == 3'b111) && (rec_i[23:0] != 24'hFFFFFF);

endmodule

// File: rtl/rec_f32_to_f32_arbiter.sv
// Round-robin shares one recoded-F32 -> IEEE-F32 converter among NUM_REQ requesters; counts bad NaNs.
// Latency: accept in cycle N gives io_resp_valid in cycle N+2, one result per cycle sustained.
// Backpressure: resp_ready low holds s1, then s0; all req_ready drop once both stages are full.
module rec_f32_to_f32_arbiter
    import rec_fn_pkg::*;
(
    input  logic                         clk,
    input  logic                         reset,
    rec_f32_to_f32_arbiter_if.slave      io
);

    logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
    s0_entry_t        s0_q, s0_d;
    logic             s0_valid_q, s0_valid_d;
    s1_entry_t        s1_q, s1_d;
    logic             s1_valid_q, s1_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             grant_found;
    logic [SRC_W-1:0] grant_idx;
    logic [SRC_W-1:0] cand;
    logic             s1_can_load;
    logic             s0_can_load;
    logic             accept;
    logic             resp_fire;
    logic [F32_W-1:0] core_bits;
    logic             core_bad;

    assign s1_can_load = !s1_valid_q || io.io_resp_ready;
    assign s0_can_load = !s0_valid_q || s1_can_load;
    // Reset gates the grant so no requester sees ready while the unit is held.
    assign accept      = grant_found && s0_can_load && !reset;
    assign resp_fire   = s1_valid_q && io.io_resp_ready;

    rec_f32_to_f32_core u_core (
        .rec_i        (s0_q.op),
        .f32_o        (core_bits),
        .is_bad_nan_o (core_bad)
    );

    // Pick the first valid requester at or after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = SRC_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!grant_found && io.io_req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Ready goes only to the granted requester, and only when s0 can take it.
    always_comb begin
        io.io_req_ready = '0;
        if (accept) begin
            io.io_req_ready[grant_idx] = 1'b1;
        end
    end

    // Pipeline advance: s1 drains/reloads, s0 moves up and refills in the same cycle.
    always_comb begin
        s0_valid_d = s0_valid_q;
        s0_d       = s0_q;
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        rr_ptr_d   = rr_ptr_q;
        if (s1_can_load) begin
            s1_valid_d = s0_valid_q;
            if (s0_valid_q) begin
                s1_d.src        = s0_q.src;
                s1_d.is_bad_nan = core_bad;
                s1_d.bits       = core_bits;
            end
            s0_valid_d = 1'b0;
        end
        if (accept) begin
            s0_valid_d = 1'b1;
            s0_d.src   = grant_idx;
            s0_d.op    = io.io_req_bits[REC_F32_W*int'(grant_idx) +: REC_F32_W];
            rr_ptr_d   = wrap_inc(grant_idx);
        end
    end

    // Bad-NaN counter: clear has priority, increment saturates at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (io.io_badNaN_clear) begin
            cnt_d = '0;
        end else if (resp_fire && s1_q.is_bad_nan && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State registers; reset drops anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q   <= '0;
            s0_q       <= '0;
            s0_valid_q <= 1'b0;
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            s0_q       <= s0_d;
            s0_valid_q <= s0_valid_d;
            s1_q       <= s1_d;
            s1_valid_q <= s1_valid_d;
            cnt_q      <= cnt_d;
        end
    end

    assign io.io_resp_valid    = s1_valid_q;
    assign io.io_resp_bits     = s1_q.bits;
    assign io.io_resp_src      = s1_q.src;
    assign io.io_resp_isBadNaN = s1_q.is_bad_nan;
    assign io.io_badNaN_count  = cnt_q;

    // At most one requester is ever granted.
    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(io.io_req_ready));

    // A stalled result must not change under the consumer.
    a_resp_stable: assert property (@(posedge clk) disable iff (reset)
        (io.io_resp_valid && !io.io_resp_ready) |=>
        (io.io_resp_valid && $stable(io.io_resp_bits) && $stable(io.io_resp_src)
         && $stable(io.io_resp_isBadNaN)));

endmodule

// File: tb/tb_rec_f32_to_f32_arbiter.sv
// Randomised bench for the shared recoded-F32 converter with a queue-based reference model.
// Latency: model expects a result two sampled cycles after its accept.
// Backpressure: model allows an accept unless two items are in flight and resp_ready is low.
module tb_rec_f32_to_f32_arbiter;
    import rec_fn_pkg::*;

    logic clk;
    logic reset;

    rec_f32_to_f32_arbiter_if io();

    rec_f32_to_f32_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .io    (io)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference conversion from the format rules, using integer arithmetic.
    function automatic logic [31:0] ref_conv(input logic [32:0] op);
        int e, f, sig, sh, ex, fr;
        logic s;
        s  = op[32];
        e  = int'(op >> 23) & 511;
        f  = int'(op & 33'h7FFFFF);
        ex = 0;
        fr = 0;
        if (e < 64) begin
            ex = 0; fr = 0;
        end else if (e >= 384 && e < 448) begin
            ex = 255; fr = 0;
        end else if (e >= 448) begin
            ex = 255; fr = f;
        end else if (e < 130) begin
            sig = (f + (1 << 23)) / 2;
            sh  = (1 - (e % 32) + 64) % 32;
            ex  = 0;
            fr  = (sig >> sh) % (1 << 23);
        end else begin
            ex = (e - 129) % 256;
            fr = f;
        end
        return {s, 8'(ex), 23'(fr)};
    endfunction

    function automatic bit ref_bad(input logic [32:0] op);
        return ((int'(op >> 29) & 7) == 7) && ((op & 33'hFFFFFF) != 33'hFFFFFF);
    endfunction

    // Operand generator biased to hit every exponent class.
    function automatic logic [32:0] rand_op();
        logic [32:0] r;
        int k, e;
        r[31:0] = $urandom;
        r[32]   = 1'($urandom_range(0, 1));
        k       = $urandom_range(0, 5);
        case (k)
            0:       e = $urandom_range(0, 63);
            1:       e = $urandom_range(384, 447);
            2:       e = $urandom_range(448, 511);
            3:       e = $urandom_range(64, 129);
            4:       e = $urandom_range(130, 383);
            default: e = -1;
        endcase
        if (e >= 0) r[31:23] = 9'(e);
        if (k == 2 && $urandom_range(0, 1) == 1) r[23:0] = 24'hFFFFFF;
        return r;
    endfunction

    typedef struct {
        logic [31:0] bits;
        int          src;
        bit          bad;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   m_ptr = 0;
    int   m_cnt = 0;
    int   cyc   = 0;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Reference model and scoreboard, evaluated mid-cycle on stable inputs.
    always @(negedge clk) begin : monitor
        int          g;
        logic [NUM_REQ-1:0] exp_rdy;
        bit          can, exp_v, fire;
        exp_t        ent;
        logic [32:0] op;
        if (reset) begin
            check_eq("rst_req_ready", io.io_req_ready, 0);
            check_eq("rst_resp_valid", io.io_resp_valid, 0);
            check_eq("rst_resp_bits", io.io_resp_bits, 0);
            check_eq("rst_resp_src", io.io_resp_src, 0);
            check_eq("rst_resp_bad", io.io_resp_isBadNaN, 0);
            check_eq("rst_count", io.io_badNaN_count, 0);
            q.delete();
            m_ptr = 0;
            m_cnt = 0;
        end else begin
            cyc++;
            can     = (q.size() < 2) || io.io_resp_ready;
            g       = -1;
            exp_rdy = '0;
            if (can) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    if (g < 0 && io.io_req_valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
                end
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
            check_eq("req_ready", io.io_req_ready, exp_rdy);
            exp_v = (q.size() > 0) && (cyc - q[0].cyc >= 2);
            check_eq("resp_valid", io.io_resp_valid, exp_v);
            if (exp_v && io.io_resp_valid) begin
                check_eq("resp_bits", io.io_resp_bits, q[0].bits);
                check_eq("resp_src", io.io_resp_src, q[0].src);
                check_eq("resp_bad", io.io_resp_isBadNaN, q[0].bad);
            end
            check_eq("count", io.io_badNaN_count, m_cnt);
            fire = exp_v && io.io_resp_ready;
            if (io.io_badNaN_clear) m_cnt = 0;
            else if (fire && q[0].bad && m_cnt < CNT_MAX) m_cnt++;
            if (fire) void'(q.pop_front());
            if (g >= 0) begin
                op       = io.io_req_bits[33*g +: 33];
                ent.bits = ref_conv(op);
                ent.src  = g;
                ent.bad  = ref_bad(op);
                ent.cyc  = cyc;
                q.push_back(ent);
                m_ptr = (g + 1) % NUM_REQ;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One operand from requester 0 with a literal expectation two cycles later.
    task automatic send_one(input string tag, input logic [32:0] op,
                            input logic [31:0] exp_bits, input bit exp_bad);
        io.io_req_bits[32:0] = op;
        io.io_req_valid      = 4'b0001;
        tick();
        io.io_req_valid = '0;
        @(negedge clk);
        check_eq({tag, "_lat1_valid"}, io.io_resp_valid, 0);
        tick();
        @(negedge clk);
        check_eq({tag, "_valid"}, io.io_resp_valid, 1);
        check_eq({tag, "_bits"}, io.io_resp_bits, exp_bits);
        check_eq({tag, "_src"}, io.io_resp_src, 0);
        check_eq({tag, "_bad"}, io.io_resp_isBadNaN, exp_bad);
        tick();
        tick();
    endtask

    task automatic randomize_bits();
        for (int i = 0; i < NUM_REQ; i++) io.io_req_bits[33*i +: 33] = rand_op();
    endtask

    initial begin
        reset              = 1'b0;
        io.io_req_valid    = '0;
        io.io_req_bits     = '0;
        io.io_resp_ready   = 1'b1;
        io.io_badNaN_clear = 1'b0;
        #2;
        do_reset();

        // Directed conversions.
        send_one("one",   33'h0_8000_0000, 32'h3F80_0000, 1'b0);
        send_one("zero",  33'h0_0000_0000, 32'h0000_0000, 1'b0);
        send_one("pinf",  33'h0_C000_0000, 32'h7F80_0000, 1'b0);
        send_one("ninf",  33'h1_C000_0000, 32'hFF80_0000, 1'b0);
        send_one("two",   33'h0_8080_0000, 32'h4000_0000, 1'b0);
        send_one("subn",  33'h0_4080_0000, 32'h0040_0000, 1'b0);
        @(negedge clk);
        check_eq("cnt_before_nan", io.io_badNaN_count, 0);
        send_one("nan",   33'h0_E040_0000, 32'h7FC0_0000, 1'b1);
        @(negedge clk);
        check_eq("cnt_after_nan", io.io_badNaN_count, 1);
        tick();

        // Round-robin order from a fresh pointer with everyone requesting.
        do_reset();
        io.io_req_valid = '1;
        for (int i = 0; i < 8; i++) begin
            randomize_bits();
            @(negedge clk);
            check_eq("rr_grant", io.io_req_ready, 4'b0001 << (i % 4));
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            randomize_bits();
            tick();
        end

        // Stall with a full pipe, then release.
        io.io_resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            randomize_bits();
            tick();
        end
        @(negedge clk);
        check_eq("stall_req_ready", io.io_req_ready, 0);
        check_eq("stall_resp_valid", io.io_resp_valid, 1);
        tick();
        io.io_resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            randomize_bits();
            tick();
        end

        // Random traffic, random backpressure, occasional clears.
        for (int i = 0; i < 400; i++) begin
            io.io_req_valid    = 4'($urandom_range(0, 15));
            io.io_resp_ready   = ($urandom_range(0, 9) < 7);
            io.io_badNaN_clear = ($urandom_range(0, 99) < 3);
            randomize_bits();
            tick();
        end
        io.io_badNaN_clear = 1'b0;

        // Reset with both stages full.
        io.io_req_valid  = '1;
        io.io_resp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            randomize_bits();
            tick();
        end
        reset = 1'b1;
        #1;
        check_eq("async_rst_valid", io.io_resp_valid, 0);
        tick();
        tick();
        io.io_req_valid  = '0;
        reset            = 1'b0;
        io.io_resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();

        // Clear coinciding with a bad-NaN result.
        send_one("nan2", 33'h0_E040_0000, 32'h7FC0_0000, 1'b1);
        io.io_req_bits[32:0] = 33'h0_E040_0000;
        io.io_req_valid      = 4'b0001;
        tick();
        io.io_req_valid = '0;
        tick();
        io.io_badNaN_clear = 1'b1;
        tick();
        io.io_badNaN_clear = 1'b0;
        @(negedge clk);
        check_eq("clear_wins", io.io_badNaN_count, 0);
        tick();

        // Saturation of the bad-NaN counter.
        io.io_req_bits  = {4{33'h0_E040_0000}};
        io.io_req_valid = '1;
        for (int i = 0; i < (1 << CNT_W) + 8; i++) tick();
        io.io_req_valid = '0;
        for (int i = 0; i < 4; i++) tick();
        @(negedge clk);
        check_eq("cnt_saturated", io.io_badNaN_count, CNT_MAX);
        check_eq("drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
